// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and defaults for the iterative divider
package div_unit_pkg;

  // Datapath width of the MiniMIPS32 word bus; the divider defaults to it.
  localparam int WORD_BUS_W = 32;
  localparam int DIV_WIDTH  = WORD_BUS_W;

  // Divider sequencing states (2-bit encoding).
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between pipeline control and divider
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side (EXE stage controller).
  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_unit_abs.sv
// rtl/div_unit_abs.sv - conditional two's-complement negate
module div_unit_abs #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] res_o
);

  // Negating the most negative value yields itself, which is exactly the
  // magnitude the restoring loop expects when read as unsigned.
  assign res_o = neg_i ? (WIDTH'(0) - val_i) : val_i;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring signed/unsigned divider with start/busy/done
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst,
  div_unit_if.slave  bus
);

  div_state_e       state_q;
  logic             signed_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic             zero_q;
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude, becomes quotient as bits shift in
  logic [WIDTH-1:0] dvs_q;      // divisor magnitude
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_out_q;

  logic             dvd_neg_in;
  logic             dvs_neg_in;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             quot_neg;
  logic             rem_neg;
  logic [WIDTH-1:0] rem_src;
  logic [WIDTH-1:0] quot_fixed;
  logic [WIDTH-1:0] rem_fixed;

  // Operand sign detection only applies in signed mode.
  assign dvd_neg_in = bus.signed_div & bus.dividend[WIDTH-1];
  assign dvs_neg_in = bus.signed_div & bus.divisor[WIDTH-1];

  div_unit_abs #(.WIDTH(WIDTH)) u_dvd_abs (
    .neg_i (dvd_neg_in),
    .val_i (bus.dividend),
    .res_o (dvd_mag)
  );

  div_unit_abs #(.WIDTH(WIDTH)) u_dvs_abs (
    .neg_i (dvs_neg_in),
    .val_i (bus.divisor),
    .res_o (dvs_mag)
  );

  // One restoring step: shift next dividend bit in, trial-subtract, keep or restore.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    qbit    = ~diff[WIDTH];
    rem_d   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], qbit};
  end

  // Sign fix-up. On divide-by-zero dvd_q still holds the untouched magnitude,
  // so re-applying the dividend sign reproduces the original dividend.
  assign quot_neg = signed_q & (dvd_neg_q ^ dvs_neg_q);
  assign rem_neg  = signed_q & dvd_neg_q;
  assign rem_src  = zero_q ? dvd_q : rem_q;

  div_unit_abs #(.WIDTH(WIDTH)) u_quot_fix (
    .neg_i (quot_neg),
    .val_i (dvd_q),
    .res_o (quot_fixed)
  );

  div_unit_abs #(.WIDTH(WIDTH)) u_rem_fix (
    .neg_i (rem_neg),
    .val_i (rem_src),
    .res_o (rem_fixed)
  );

  // Sequencer: accept, iterate, fix up signs, pulse done; cancel aborts silently.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q   <= DIV_IDLE;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rem_out_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.cancel) begin
            signed_q  <= bus.signed_div;
            dvd_neg_q <= dvd_neg_in;
            dvs_neg_q <= dvs_neg_in;
            zero_q    <= (bus.divisor == '0);
            dvd_q     <= dvd_mag;
            dvs_q     <= dvs_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= (bus.divisor == '0) ? DIV_FIX : DIV_CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          if (bus.cancel) begin
            busy_q  <= 1'b0;
            state_q <= DIV_IDLE;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= DIV_FIX;
            end
          end
        end
        DIV_FIX: begin
          if (bus.cancel) begin
            busy_q  <= 1'b0;
            state_q <= DIV_IDLE;
          end else begin
            quot_q    <= zero_q ? '1 : quot_fixed;
            rem_out_q <= rem_fixed;
            dbz_q     <= zero_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= DIV_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .bus         (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           issue;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_done = -1;
  int   prev_done = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      prev_done = last_done;
      last_done = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", bus.quotient, e.q);
        chk("remainder", bus.remainder, e.r);
        chk("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        chk("latency", cyc - e.issue - 1, e.lat);
        chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
      end
    end
  end

  // Called at a negedge: present a request for one cycle, optionally expect a result.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                       input int lat, input bit push);
    exp_t e;
    bus.signed_div = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.start      = 1'b1;
    e.q = q; e.r = r; e.dbz = dbz; e.issue = cyc; e.lat = lat;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending after %0d cycles expected 0", name, sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic chk_outputs(input string name, input logic b, input logic d,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    chk({name, "_busy"}, {31'd0, bus.busy}, {31'd0, b});
    chk({name, "_done"}, {31'd0, bus.done}, {31'd0, d});
    chk({name, "_quotient"}, bus.quotient, q);
    chk({name, "_remainder"}, bus.remainder, r);
    chk({name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, z});
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

  initial begin : stim
    int nb;
    int n;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.cancel     = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (3) @(negedge clk);
    chk_outputs("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 100/7 with busy-width measurement.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 1, 1'b1);
    nb = 0;
    @(negedge clk);
    while (bus.busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, W + 1);
    wait_idle("t1");

    // A start while busy must not disturb the running operation.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W + 1, 1'b1);
    repeat (5) @(negedge clk);
    bus.dividend = 32'd9; bus.divisor = 32'd4; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_idle("t1b");

    // Signed and unsigned views of the same operands.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, W + 1, 1'b1);
    wait_idle("t2s");
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, W + 1, 1'b1);
    wait_idle("t2u");

    // Signed overflow and unsigned max.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, W + 1, 1'b1);
    wait_idle("t3s");
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, W + 1, 1'b1);
    wait_idle("t3u");

    // Divide by zero, with an ignored start during the busy cycle.
    issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    @(negedge clk);
    chk("dbz_busy", {31'd0, bus.busy}, 32'd1);
    bus.dividend = 32'd9; bus.divisor = 32'd4; bus.signed_div = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    wait_idle("t4s");
    @(negedge clk);
    chk("dbz_no_restart", {31'd0, bus.busy}, 32'd0);
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    wait_idle("t4u");
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b1);
    wait_idle("t4n");

    // Cancel mid-calculation: no done, previous results held.
    issue(1'b0, 32'd20, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk); #1; bus.cancel = 1'b0;
    @(negedge clk);
    chk_outputs("cancel", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    repeat (40) @(negedge clk);
    chk("cancel_stays_idle", {31'd0, bus.busy}, 32'd0);

    // Start and cancel together: cancel wins.
    bus.dividend = 32'd9; bus.divisor = 32'd4; bus.start = 1'b1; bus.cancel = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.cancel = 1'b0;
    @(negedge clk);
    chk("start_cancel_busy", {31'd0, bus.busy}, 32'd0);

    issue(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, W + 1, 1'b1);
    wait_idle("t5");

    // Reset mid-calculation clears everything.
    issue(1'b0, 32'd20, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_outputs("midrst", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (40) @(negedge clk);
    chk("midrst_idle", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: second start presented in the DONE cycle.
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, W + 1, 1'b1);
    n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    issue(1'b0, 32'd51, 32'd5, 32'd10, 32'd1, 1'b0, W + 1, 1'b1);
    wait_idle("t6");
    chk("done_spacing", last_done - prev_done, W + 2);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
